// File: rtl/seg_scan_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Only one anode is driven at a time, and that digit's nibble is presented to
// the shared BCD_to_7seg decoder. Each digit slot starts with a short blank
// period, with all anodes off, to prevent ghosting. New display contents are
// double-buffered: a load fills the pending buffer, and the pending buffer is
// copied into the active buffer only at the frame wrap. A frame therefore
// never shows a mix of old and new digits.
//
// Parameters
//   REFRESH_DIV   clocks per digit slot. Must be greater than BLANK_CYCLES.
//   BLANK_CYCLES  clocks at the start of each slot with all anodes off (>= 1).
//
// Ports
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   digit_data   eight BCD nibbles; [3:0] is digit 0 (rightmost)
//   digit_en     per-digit enable, sampled live; 0 keeps that anode off
//   dp_mask      per-digit decimal point (1 = lit), sampled live
//   load         one-cycle strobe that captures digit_data into the pending buffer
//   anode        active-low digit selects; at most one bit is low
//   bcd_q        nibble for the current digit, to the decoder
//   dp_n         active-low decimal point for the current digit
//   digit_idx    index of the current slot
//   frame_start  one-cycle pulse in the first blank cycle after the index wraps to 0
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN)
//   When this macro is defined, leading zeros in the active buffer are kept
//   dark. Digit 0 is never suppressed. Slot timing does not change.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digit_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  input  logic        load,
  output logic [7:0]  anode,
  output logic [3:0]  bcd_q,
  output logic        dp_n,
  output logic [2:0]  digit_idx,
  output logic        frame_start
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx_nxt;
  logic             wrap;

  logic [31:0]      active, active_nxt;
  logic [31:0]      pending;
  logic             pend_valid, pend_valid_nxt;
  logic             commit;

  logic [7:0]       suppress;
  logic [7:0]       anode_d;
  logic [3:0]       bcd_d;
  logic             dp_n_d;

  // ---------------------------------------------------------------------------
  // State register. The outputs are registered here as well. They are built
  // from next-state values, so each output lines up with the slot phase it
  // belongs to.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values and simulation matches the synthesized flops.
  // NOTE: the digit buffers are small and must read as zero after reset, so
  // they get an async reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      digit_idx   <= 3'd0;
      active      <= '0;
      pending     <= '0;
      pend_valid  <= 1'b0;
      anode       <= 8'hFF;
      bcd_q       <= 4'd0;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      digit_idx   <= idx_nxt;
      active      <= active_nxt;
      pend_valid  <= pend_valid_nxt;
      if (load) begin
        pending <= digit_data;
      end
      anode       <= anode_d;
      bcd_q       <= bcd_d;
      dp_n        <= dp_n_d;
      frame_start <= wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: slot counter, FSM and digit index.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = digit_idx;
    wrap      = 1'b0;
    unique case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = digit_idx + 3'd1;
          wrap      = (digit_idx == 3'd7);
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double buffer. The commit reads pending before this cycle's load
  // overwrites it. A load that coincides with the commit therefore stays
  // pending for the next frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    commit         = wrap && pend_valid;
    active_nxt     = commit ? pending : active;
    pend_valid_nxt = pend_valid;
    if (commit) begin
      pend_valid_nxt = 1'b0;
    end
    if (load) begin
      pend_valid_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression. This is computed from the active buffer value
  // that will be on display in the next cycle.
  // ---------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    suppress    = '0;
    // Walk down from digit 7. A digit goes dark only while it and every
    // digit above it are zero.
    for (int i = 7; i >= 1; i--) begin
      higher_zero = higher_zero & (active_nxt[4*i +: 4] == 4'd0);
      suppress[i] = higher_zero;
    end
  end
`else
  assign suppress = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output logic. bcd_q tracks the slot's digit in both states, so the
  // decoder has already settled when the anode turns on.
  // ---------------------------------------------------------------------------
  always_comb begin
    anode_d = 8'hFF;
    dp_n_d  = 1'b1;
    bcd_d   = active_nxt[{idx_nxt, 2'b00} +: 4];
    if (state_nxt == ST_DRIVE && !suppress[idx_nxt]) begin
      anode_d[idx_nxt] = ~digit_en[idx_nxt];
      dp_n_d           = ~dp_mask[idx_nxt];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl with REFRESH_DIV=4 and BLANK_CYCLES=1,
// which gives a 32-clock frame.
//
// The reference model counts clock edges since reset release. From that count
// it derives the slot and the offset within the slot, then applies the display
// rules directly. The outputs are compared on every falling edge. Directed
// literal checks at chosen cycles pin the model itself.
//
// Build with +define+LEADING_ZERO_BLANK_EN to also exercise leading-zero
// blanking.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] digit_data = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  dp_mask = 8'h00;
  logic        load = 1'b0;
  logic [7:0]  anode;
  logic [3:0]  bcd_q;
  logic        dp_n;
  logic [2:0]  digit_idx;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  int          m_k = 0;           // clock edges since reset release
  logic [31:0] m_active = '0;
  logic [31:0] m_pending = '0;
  logic        m_pv = 1'b0;
  logic [7:0]  e_anode = 8'hFF;
  logic [3:0]  e_bcd = 4'd0;
  logic        e_dp_n = 1'b1;
  logic [2:0]  e_idx = 3'd0;
  logic        e_fs = 1'b0;

  seg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_data (digit_data),
    .digit_en   (digit_en),
    .dp_mask    (dp_mask),
    .load       (load),
    .anode      (anode),
    .bcd_q      (bcd_q),
    .dp_n       (dp_n),
    .digit_idx  (digit_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (k=%0d, t=%0t)", name, act, exp, m_k, $time);
    end
  endtask

  // Advance to the falling edge that follows clock edge number 'target'.
  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (m_k < target && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (m_k != target) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_k: reached k=%0d, expected k=%0d", m_k, target);
    end
  endtask

  // Issue a single-cycle load, sampled at clock edge k+1.
  task automatic do_load(input logic [31:0] value);
    digit_data = value;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the slot position follows from the edge count. The
  // buffers follow the load/commit rules.
  // ---------------------------------------------------------------------------
  initial begin
    int  pos, slot, off;
    bit  lit;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_k       = 0;
        m_active  = '0;
        m_pending = '0;
        m_pv      = 1'b0;
        e_anode   = 8'hFF;
        e_bcd     = 4'd0;
        e_dp_n    = 1'b1;
        e_idx     = 3'd0;
        e_fs      = 1'b0;
      end else begin
        m_k++;
        pos  = m_k % FRAME;
        slot = pos / RD;
        off  = pos % RD;
        e_fs = (pos == 0);
        if (pos == 0 && m_pv) begin
          m_active = m_pending;
          m_pv     = 1'b0;
        end
        if (load) begin
          m_pending = digit_data;
          m_pv      = 1'b1;
        end
        e_idx   = 3'(slot);
        e_bcd   = 4'((m_active >> (4 * slot)) & 32'hF);
        e_anode = 8'hFF;
        e_dp_n  = 1'b1;
        lit     = (off >= BC);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot != 0 && (m_active >> (4 * slot)) == 32'd0) lit = 1'b0;
`endif
        if (lit) begin
          if (digit_en[slot]) e_anode[slot] = 1'b0;
          e_dp_n = ~dp_mask[slot];
        end
      end
    end
  end

  // Compare on every falling edge, away from the active clock edge.
  initial begin
    forever begin
      @(negedge clk);
      check("anode", 32'(anode), 32'(e_anode));
      check("bcd_q", 32'(bcd_q), 32'(e_bcd));
      check("dp_n", 32'(dp_n), 32'(e_dp_n));
      check("digit_idx", 32'(digit_idx), 32'(e_idx));
      check("frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // ---------------------------------------------------------------------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_anode", 32'(anode), 32'h0000_00FF);
    check("rst_bcd", 32'(bcd_q), 32'h0);
    check("rst_dp_n", 32'(dp_n), 32'h1);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    rst_n = 1'b1;

    // Slot 0: blank for one clock, then driven.
    check("slot0_blank_anode", 32'(anode), 32'h0000_00FF);
    wait_k(1);
    check("slot0_drive_anode", 32'(anode), 32'h0000_00FE);
    check("slot0_drive_bcd", 32'(bcd_q), 32'h0);

    // Full scan: the load in frame 0 becomes visible in frame 1.
    do_load(32'h8765_4321);
    wait_k(13);
    check("frame0_still_zero", 32'(bcd_q), 32'h0);
    wait_k(32);
    check("frame1_start", 32'(frame_start), 32'h1);
    check("frame1_slot0_bcd", 32'(bcd_q), 32'h1);
    wait_k(45);
    check("frame1_slot3_anode", 32'(anode), 32'h0000_00F7);
    check("frame1_slot3_bcd", 32'(bcd_q), 32'h4);
    wait_k(61);
    check("frame1_slot7_anode", 32'(anode), 32'h0000_007F);
    check("frame1_slot7_bcd", 32'(bcd_q), 32'h8);
    wait_k(64);
    check("frame2_start", 32'(frame_start), 32'h1);

    // Commit collision: a load on the commit edge waits for the next frame.
    wait_k(70);
    do_load(32'h1111_1111);
    wait_k(95);
    do_load(32'h2222_2222);
    wait_k(97);
    check("collision_frame3_bcd", 32'(bcd_q), 32'h1);
    wait_k(125);
    check("collision_frame3_slot7", 32'(bcd_q), 32'h1);
    wait_k(129);
    check("collision_frame4_bcd", 32'(bcd_q), 32'h2);

    // Enables and decimal point.
    digit_en = 8'b1010_1010;
    dp_mask  = 8'h04;
    wait_k(165);
    check("en_slot1_anode", 32'(anode), 32'h0000_00FD);
    check("en_slot1_dp_n", 32'(dp_n), 32'h1);
    wait_k(169);
    check("en_slot2_anode", 32'(anode), 32'h0000_00FF);
    check("en_slot2_dp_n", 32'(dp_n), 32'h0);
    wait_k(192);
    check("en_frame_len", 32'(frame_start), 32'h1);
    digit_en = 8'hFF;
    dp_mask  = 8'h00;

    // Reset in the middle of DRIVE in slot 5, with a load still pending.
    wait_k(200);
    do_load(32'h9999_9999);
    wait_k(213);
    check("pre_reset_slot5_anode", 32'(anode), 32'h0000_00DF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_anode", 32'(anode), 32'h0000_00FF);
    check("async_reset_idx", 32'(digit_idx), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_k(1);
    check("post_reset_idx", 32'(digit_idx), 32'h0);
    check("post_reset_anode", 32'(anode), 32'h0000_00FE);
    wait_k(32);
    check("post_reset_frame_start", 32'(frame_start), 32'h1);
    wait_k(33);
    check("pending_discarded", 32'(bcd_q), 32'h0);

`ifdef LEADING_ZERO_BLANK_EN
    // Leading-zero blanking with active = 0x00000120.
    wait_k(34);
    do_load(32'h0000_0120);
    wait_k(65);
    check("lzb_slot0_anode", 32'(anode), 32'h0000_00FE);
    check("lzb_slot0_bcd", 32'(bcd_q), 32'h0);
    wait_k(69);
    check("lzb_slot1_anode", 32'(anode), 32'h0000_00FD);
    check("lzb_slot1_bcd", 32'(bcd_q), 32'h2);
    wait_k(73);
    check("lzb_slot2_anode", 32'(anode), 32'h0000_00FB);
    check("lzb_slot2_bcd", 32'(bcd_q), 32'h1);
    wait_k(77);
    check("lzb_slot3_dark", 32'(anode), 32'h0000_00FF);
    wait_k(80);
    do_load(32'h0000_0000);
    wait_k(93);
    check("lzb_slot7_dark", 32'(anode), 32'h0000_00FF);
    wait_k(97);
    check("lzb_zero_slot0_lit", 32'(anode), 32'h0000_00FE);
    wait_k(101);
    check("lzb_zero_slot1_dark", 32'(anode), 32'h0000_00FF);
`endif

    wait_k(130);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display. It shares the single BCD_to_7seg decoder among eight digit values by driving one anode at a time and presenting that digit's nibble on bcd_q. New display contents are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new digits. It sits between the pattern/generation logic, which supplies the digit values, and the BCD_to_7seg decoder and board anode pins.

Parameters:
REFRESH_DIV, 100000, clocks per digit slot (100 MHz gives 1 kHz per digit, 125 Hz per frame); must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, clocks at the start of each slot with all anodes off (anti-ghosting); must be at least 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
digit_data  input  32  eight BCD nibbles; [3:0] is digit 0 (rightmost), [31:28] is digit 7
digit_en  input  8  per-digit enable, sampled live; a 0 keeps that anode off
dp_mask  input  8  per-digit decimal point, 1 = lit; sampled live
load  input  1  one-cycle strobe that captures digit_data into the pending buffer
anode  output  8  active-low digit selects; at most one bit low at any time
bcd_q  output  4  nibble for the current digit, to BCD_to_7seg .Q
dp_n  output  1  active-low decimal point for the current digit
digit_idx  output  3  index of the current slot
frame_start  output  1  one-cycle pulse when a new frame begins (index wraps to 0)

Behaviour:
- Reset (asynchronous on rst_n low):
  - anode = 8'hFF, bcd_q = 0, dp_n = 1, digit_idx = 0, frame_start = 0.
  - Active buffer and pending buffer cleared to 0; pend_valid = 0.
  - Slot counter = 0; FSM enters BLANK.
- All outputs are registered.
- FSM has two states:
  - BLANK: anode = 8'hFF, dp_n = 1. bcd_q already holds active[idx], so the decoder settles before the anode turns on. Lasts BLANK_CYCLES clocks, then goes to DRIVE.
  - DRIVE: anode[idx] = ~digit_en[idx] and all other bits are 1; dp_n = ~dp_mask[idx]. Lasts REFRESH_DIV - BLANK_CYCLES clocks.
- End of DRIVE: idx <= idx + 1 (wraps 7 -> 0), counter resets, FSM returns to BLANK. Slot period is exactly REFRESH_DIV clocks; frame period is 8 * REFRESH_DIV.
- Frame wrap (idx 7 -> 0): frame_start = 1 for exactly the first BLANK cycle of slot 0. If pend_valid is set, active <= pending and pend_valid <= 0 in that same cycle, so slot 0 shows the new data.
- Load: pending <= digit_data and pend_valid <= 1. Multiple loads within one frame: the last one wins.
- Load in the same cycle as a commit: the commit uses the pre-load pending value; the new load is captured and pend_valid stays 1, so it commits at the next frame.
- Nibble values 10-15 pass through unchanged; the decoder defines their glyphs.
- digit_en and dp_mask changes take effect on the next clock, even mid-slot.
- Reset asserted mid-slot: outputs go to reset values immediately; no partial commit survives.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a digit is forced dark (anode bit stays 1, dp_n = 1) when its active nibble is 0 and every higher-index active nibble is also 0. Digit 0 is never suppressed. Suppression is computed from the active buffer only; slot timing is unchanged.
- Not defined: zeros display normally; only digit_en and dp_mask affect visibility.

Test Plan:
- Reset / blank slot (REFRESH_DIV=4, BLANK_CYCLES=1): hold rst_n low, then release; digit_en=8'hFF, no load.
  -> anode=8'hFF and bcd_q=0 during reset.
  -> Slot 0 shows anode=8'hFF for 1 clock, then 8'hFE for 3 clocks, with bcd_q=0.
- Full scan: load digit_data=32'h87654321 during frame 0.
  -> Frame 0 keeps showing zeros.
  -> Frame 1 anode sequence is FE, FD, FB, F7, EF, DF, BF, 7F, with bcd_q = 1, 2, 3, 4, 5, 6, 7, 8.
  -> frame_start pulses every 32 clocks.
- Commit collision: load 32'h11111111 mid-frame, then load 32'h22222222 in the exact cycle of the frame wrap.
  -> The next frame shows all 1s.
  -> The following frame shows all 2s.
- Enables and decimal point: digit_en=8'b1010_1010, dp_mask=8'h04.
  -> anode never goes low in even-index slots.
  -> dp_n=0 only in slot 2, and there anode stays FF and the dp does not appear.
  -> The scan still takes 8 slots per frame.
- Reset mid-DRIVE in slot 5 with pend_valid=1.
  -> anode=8'hFF immediately (asynchronous).
  -> After release, digit_idx=0 and the active buffer = 0.
  -> The pending load is discarded.
- LEADING_ZERO_BLANK_EN defined, active=32'h00000120.
  -> Slots 3-7 stay dark.
  -> Slots 0-2 light with bcd_q = 0, 2, 1.
  -> With active=0, only slot 0 lights.
